instr_mem_responder: RTL



---
 rtl/instr_mem_responder.sv | 85 ++++++++
 1 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: a byte-loadable memory that returns a little-endian
// 32-bit word after LATENCY wait cycles, stalling the CPU through BUSYWAIT.
module instr_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4   // legal range 1..15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       ADDRESS,
  input  logic              READ,
  output logic [31:0]       INSTRUCTION,
  output logic              BUSYWAIT,
  input  logic              LOAD_EN,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  input  logic [7:0]        LOAD_DATA
);

  localparam int         WORD_W   = ADDR_W - 2;
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [3:0]        r_count;
  logic [WORD_W-1:0] r_addr_q;
  logic [7:0]        r_mem [DEPTH];

  logic [WORD_W-1:0] w_word_addr;
  logic [31:0]       w_word;
  logic              w_hit;
  logic              w_unused;

  assign w_word_addr = ADDRESS[ADDR_W-1:2];
  assign w_unused    = ^{ADDRESS[31:ADDR_W], ADDRESS[1:0]};

  // Lane gi of the word comes from byte offset gi (little-endian).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_word[8*gi +: 8] = r_mem[{r_addr_q, 2'(gi)}];
    end
  endgenerate

  // Memory is never reset; loads may happen in any FSM state.
  always_ff @(posedge CLK) begin
    if (LOAD_EN) begin
      r_mem[LOAD_ADDR] <= LOAD_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_addr_q    <= '0;
      INSTRUCTION <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (READ) begin
            r_addr_q <= w_word_addr;
            r_count  <= CNT_INIT;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            // Reads the array before any same-edge load lands.
            INSTRUCTION <= w_word;
            r_state     <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Release the CPU only when the word presented matches the address it now drives.
  assign w_hit    = (r_state == S_RESP) && (r_addr_q == w_word_addr);
  assign BUSYWAIT = READ & ~w_hit;

endmodule
